// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, CHECK, DATA, CSUM, DONE, ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_CSUM  = 2'b11
  } err_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/inst_ram_loader_if.sv
// Byte-stream input, RAM write port and CPU status lines of the loader.
interface inst_ram_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic [1:0]  err_o;

  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, mem_wr_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, err_o
  );

  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, mem_wr_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, err_o
  );
endinterface

// File: rtl/inst_ram_loader_packer.sv
// Little-endian byte-to-word packer. word holds the last four bytes shifted in
// (first byte in [7:0]); word_valid pulses the cycle after the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  cnt,
  output logic        word_valid
);

  // Shift bytes in from the top, count position within the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && !clr && (cnt == 2'd3);
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        word <= {byte_in, word[31:8]};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Instruction RAM loader: parses SYNC/addr/count/data[/csum] frames from a
// byte stream and writes words at RAM-relative offsets while holding the CPU.
// Optional: define INST_LOADER_CSUM_EN to add a trailing checksum byte.
module inst_ram_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
  parameter int unsigned RAM_BYTES = 2048,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  inst_ram_loader_if.slave bus
);

  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_BYTES);
`ifdef INST_LOADER_CSUM_EN
  localparam state_e END_ST = CSUM;
`else
  localparam state_e END_ST = DONE;
`endif

  state_e      state, state_nx;
  err_e        err_q, err_nx;
  logic        ready, accept, is_sync, start, wr;
  logic        pk_en, pk_valid;
  logic [1:0]  pk_cnt;
  logic [31:0] pk_word;
  logic [15:0] count_q, rem_q;
  logic        len_hi_q;
  logic [31:0] off_q;
  logic [32:0] end_addr;
  logic        addr_bad, range_bad;

  assign ready    = (state != CHECK);
  assign accept   = bus.byte_valid_i && ready;
  assign is_sync  = (bus.byte_i == SYNC_BYTE);
  assign start    = accept && is_sync && (state inside {IDLE, DONE, ERR});
  assign pk_en    = accept && (state inside {ADDR, DATA});
  // The address field's word_valid lands in LEN and must not reach the RAM.
  assign wr       = pk_valid && (state != LEN);
  // The packer still holds the address through LEN and CHECK.
  assign end_addr  = {1'b0, pk_word} + {15'b0, count_q, 2'b00};
  assign addr_bad  = (pk_word[1:0] != 2'b00);
  assign range_bad = ({1'b0, pk_word} < {1'b0, RAM_BASE}) || (end_addr > RAM_END);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .en         (pk_en),
    .byte_in    (bus.byte_i),
    .word       (pk_word),
    .cnt        (pk_cnt),
    .word_valid (pk_valid)
  );

`ifdef INST_LOADER_CSUM_EN
  logic [7:0] sum_q;

  // Running sum of the data bytes of the current frame.
  always_ff @(posedge clk) begin
    if (rst || start) sum_q <= '0;
    else if (pk_en && state == DATA) sum_q <= sum_q + bus.byte_i;
  end
`endif

  // State and error code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // Next-state logic and error code updates.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE, DONE, ERR: if (start) begin
        state_nx = ADDR;
        err_nx   = ERR_NONE;
      end
      ADDR: if (accept && pk_cnt == 2'd3) state_nx = LEN;
      LEN:  if (accept && len_hi_q) state_nx = CHECK;
      CHECK: begin
        if (addr_bad) begin
          state_nx = ERR;
          err_nx   = ERR_ALIGN;
        end else if (range_bad) begin
          state_nx = ERR;
          err_nx   = ERR_RANGE;
        end else if (count_q == 16'd0) begin
          state_nx = END_ST;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: if (accept && pk_cnt == 2'd3 && rem_q == 16'd1) state_nx = END_ST;
`ifdef INST_LOADER_CSUM_EN
      CSUM: if (accept) begin
        if (8'(sum_q + bus.byte_i) == 8'h00) begin
          state_nx = DONE;
        end else begin
          state_nx = ERR;
          err_nx   = ERR_CSUM;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Length field capture, remaining word count and write offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rem_q    <= '0;
      len_hi_q <= 1'b0;
      off_q    <= '0;
    end else begin
      if (start) len_hi_q <= 1'b0;
      if (accept && state == LEN) begin
        count_q  <= {bus.byte_i, count_q[15:8]};
        len_hi_q <= !len_hi_q;
      end
      if (state == CHECK) begin
        rem_q <= count_q;
        off_q <= pk_word - RAM_BASE;
      end else begin
        if (pk_en && state == DATA && pk_cnt == 2'd3) rem_q <= rem_q - 16'd1;
        if (wr) off_q <= off_q + 32'd4;
      end
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.mem_wr_o     = wr;
  assign bus.mem_addr_o   = wr ? off_q : '0;
  assign bus.mem_data_o   = wr ? pk_word : '0;
  assign bus.cpu_hold_o   = !(state == IDLE || state == DONE);
  assign bus.done_o       = (state == DONE);
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Bench for inst_ram_loader: directed frames plus random frames, checked
// against a frame-level model (expected writes queue and final status).
module tb_inst_ram_loader;
  import inst_loader_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          BYTES = 2048;

  typedef struct { logic [31:0] off; logic [31:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_ram_loader_if bus();

  inst_ram_loader #(.RAM_BASE(BASE), .RAM_BYTES(BYTES), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [1:0] m_err;
  bit         m_hdr_ok;
  int         checks = 0;
  int         errors = 0;
  wr_t        cw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wr_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual off=%h data=%h expected none",
                   bus.mem_addr_o, bus.mem_data_o);
        end else begin
          cw = exp_q.pop_front();
          chk("wr_off", bus.mem_addr_o, cw.off);
          chk("wr_data", bus.mem_data_o, cw.data);
        end
      end
      if (bus.done_o) chk("done_no_hold", {31'b0, bus.cpu_hold_o}, 32'd0);
    end
  end

  // Frame-level model: decode header, apply checks, queue expected writes.
  task automatic model_frame();
    logic [31:0] addr;
    int cnt, s, b;
    addr = {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
    cnt  = {frame_q[6], frame_q[5]};
    m_err = 2'd0;
    if (addr % 4 != 0) m_err = 2'd1;
    else if (longint'(addr) < longint'(BASE) ||
             longint'(addr) + 4 * cnt > longint'(BASE) + BYTES) m_err = 2'd2;
    m_hdr_ok = (m_err == 2'd0);
    if (m_hdr_ok) begin
      s = 0;
      for (int k = 0; k < cnt; k++) begin
        b = 7 + 4 * k;
        exp_q.push_back('{addr - BASE + 4 * k,
                          {frame_q[b+3], frame_q[b+2], frame_q[b+1], frame_q[b]}});
        for (int j = 0; j < 4; j++) s += frame_q[b+j];
      end
`ifdef INST_LOADER_CSUM_EN
      if ((s + frame_q[7 + 4 * cnt]) % 256 != 0) m_err = 2'd3;
`endif
    end
  endtask

  task automatic build_frame(input logic [31:0] addr, input int cnt, input bit csum_ok);
    int s;
    logic [7:0] d;
    frame_q = {};
    frame_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frame_q.push_back(8'(addr >> (8 * i)));
    frame_q.push_back(8'(cnt));
    frame_q.push_back(8'(cnt >> 8));
    s = 0;
    for (int i = 0; i < 4 * cnt; i++) begin
      d = 8'($urandom);
      s += d;
      frame_q.push_back(d);
    end
`ifdef INST_LOADER_CSUM_EN
    d = 8'((256 - (s % 256)) % 256);
    if (!csum_ok) d = d ^ 8'h01;
    frame_q.push_back(d);
`else
    if (csum_ok) d = 8'h00;
`endif
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    while (!bus.byte_ready_o && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'($urandom);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(frame_q[i]);
    end
  endtask

  task automatic check_status(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_err"}, {30'b0, bus.err_o}, {30'b0, m_err});
    chk({tag, "_done"}, {31'b0, bus.done_o}, {31'b0, m_err == 2'd0});
    chk({tag, "_hold"}, {31'b0, bus.cpu_hold_o}, {31'b0, m_err != 2'd0});
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input string tag);
    model_frame();
    send_range(0, m_hdr_ok ? frame_q.size() : 7);
    check_status(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, bus.byte_ready_o}, 32'd1);
    chk({tag, "_wr"}, {31'b0, bus.mem_wr_o}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr_o, 32'd0);
    chk({tag, "_data"}, bus.mem_data_o, 32'd0);
    chk({tag, "_hold"}, {31'b0, bus.cpu_hold_o}, 32'd0);
    chk({tag, "_done"}, {31'b0, bus.done_o}, 32'd0);
    chk({tag, "_err"}, {30'b0, bus.err_o}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Stray bytes in IDLE are discarded.
    send(8'h00);
    send(8'h13);
    repeat (2) @(negedge clk);
    check_reset_outputs("stray");

    // Two-word load at the RAM base.
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef INST_LOADER_CSUM_EN
    frame_q.push_back(8'h7E);
`endif
    model_frame();
    chk("pin_t2_nwr", exp_q.size(), 2);
    chk("pin_t2_off0", exp_q[0].off, 32'h0);
    chk("pin_t2_dat0", exp_q[0].data, 32'h13);
    chk("pin_t2_off1", exp_q[1].off, 32'h4);
    chk("pin_t2_dat1", exp_q[1].data, 32'h6F);
    chk("pin_t2_err", {30'b0, m_err}, 32'd0);
    send_range(0, frame_q.size());
    check_status("t2");

    // Misaligned address, then SYNC clears the error; finish with count 0.
    frame_q = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00};
    run_frame("t3_align");
    chk("pin_t3_err", {30'b0, m_err}, 32'd1);
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef INST_LOADER_CSUM_EN
    frame_q.push_back(8'h00);
`endif
    model_frame();
    send(frame_q[0]);
    @(negedge clk);
    chk("t3_err_cleared", {30'b0, bus.err_o}, 32'd0);
    chk("t3_hold_loading", {31'b0, bus.cpu_hold_o}, 32'd1);
    send_range(1, frame_q.size());
    check_status("t5_count0");

    // Range boundaries.
    build_frame(32'h27FC, 2, 1'b1);
    run_frame("t4_over");
    chk("pin_t4_over", {30'b0, m_err}, 32'd2);
    build_frame(32'h27FC, 1, 1'b1);
    model_frame();
    chk("pin_t4_last_off", exp_q[0].off, 32'h7FC);
    send_range(0, frame_q.size());
    check_status("t4_last");
    build_frame(32'h1FFC, 1, 1'b1);
    run_frame("t4_under");
    chk("pin_t4_under", {30'b0, m_err}, 32'd2);

    // Reset after 5 data bytes: only the first word lands.
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00, 8'h6F};
    exp_q.push_back('{32'h0, 32'h13});
    for (int i = 0; i < 12; i++) send(frame_q[i]);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_pending", exp_q.size(), 0);
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle_hold", {31'b0, bus.cpu_hold_o}, 32'd0);

`ifdef INST_LOADER_CSUM_EN
    // Bad checksum: both words written, then CSUM error.
    frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
    model_frame();
    chk("pin_t6_err", {30'b0, m_err}, 32'd3);
    chk("pin_t6_nwr", exp_q.size(), 2);
    send_range(0, frame_q.size());
    check_status("t6_bad_csum");
`endif

    // Random frames, stray bytes between them.
    for (int n = 0; n < 40; n++) begin
      int sel, cnt, j;
      logic [31:0] addr;
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        cnt  = 1;
        addr = BASE + 4 * $urandom_range(0, 500) + $urandom_range(1, 3);
      end else if (sel == 1) begin
        j    = $urandom_range(1, 4);
        cnt  = $urandom_range(0, 2);
        addr = BASE - 4 * j;
      end else if (sel == 2) begin
        j    = $urandom_range(0, 2);
        cnt  = j + 1 + $urandom_range(0, 1);
        addr = BASE + BYTES - 4 * j;
      end else begin
        cnt  = $urandom_range(0, 5);
        addr = BASE + 4 * $urandom_range(0, 512 - cnt);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) send(8'($urandom_range(0, 8'hA4)));
      build_frame(addr, cnt, $urandom_range(0, 3) != 0);
      run_frame("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
